// File: rtl/reg_ctx_engine.sv
// Context save/restore sequencer driving the register-file read port 1 and write port.
// Optional running checksum of transferred words: define REG_CTX_CHECKSUM_EN.
module reg_ctx_engine #(
  parameter int DATA_W    = 16,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_save,
  input  logic              start_restore,
  output logic              busy,
  output logic              done,
  output logic [3:0]        SrcReg,
  input  logic [DATA_W-1:0] SrcData,
  output logic [3:0]        DstReg,
  output logic [DATA_W-1:0] DstData,
  output logic              WriteReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] checksum
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 15) begin : g_bad_range
    $error("reg_ctx_engine: need 0 <= FIRST_REG <= LAST_REG <= 15");
  end

  localparam logic [3:0] FIRST_IDX = 4'(FIRST_REG);
  localparam logic [3:0] LAST_IDX  = 4'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_RD,
    S_SAVE_TX,
    S_RST_RX,
    S_RST_WR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [3:0]          src_reg_q;
  logic [3:0]          dst_reg_q, dst_reg_d;
  logic [DATA_W-1:0]   dst_data_q, dst_data_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [3:0]          out_idx_q, out_idx_d;
  logic                busy_q, done_q, write_q, out_valid_q, in_ready_q;
  logic                out_hs, in_hs;

  assign out_hs = (state_q == S_SAVE_TX) && out_valid_q && out_ready;
  assign in_hs  = (state_q == S_RST_RX) && in_ready_q && in_valid;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_save) begin
          state_d = S_SAVE_RD;
          idx_d   = FIRST_IDX;
        end else if (start_restore) begin
          state_d = S_RST_RX;
          idx_d   = FIRST_IDX;
        end
      end
      S_SAVE_RD: begin
        out_data_d = SrcData;
        out_idx_d  = idx_q;
        state_d    = S_SAVE_TX;
      end
      S_SAVE_TX: begin
        if (out_hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SAVE_RD;
          end
        end
      end
      S_RST_RX: begin
        if (in_hs) begin
          dst_data_d = in_data;
          dst_reg_d  = idx_q;
          state_d    = S_RST_WR;
        end
      end
      S_RST_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_RST_RX;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output flops decode the next state so every output is a clean register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= FIRST_IDX;
      src_reg_q   <= FIRST_IDX;
      dst_reg_q   <= FIRST_IDX;
      dst_data_q  <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      write_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_reg_q   <= idx_d;
      dst_reg_q   <= dst_reg_d;
      dst_data_q  <= dst_data_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      write_q     <= (state_d == S_RST_WR);
      out_valid_q <= (state_d == S_SAVE_TX);
      in_ready_q  <= (state_d == S_RST_RX);
    end
  end

`ifdef REG_CTX_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == S_IDLE && (start_save || start_restore)) begin
      sum_d = '0;
    end else if (out_hs) begin
      sum_d = sum_q + out_data_q;
    end else if (in_hs) begin
      sum_d = sum_q + in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign SrcReg    = src_reg_q;
  assign DstReg    = dst_reg_q;
  assign DstData   = dst_data_q;
  assign WriteReg  = write_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Bench for reg_ctx_engine: behavioural register-file model, random handshakes, directed scenarios.
module tb_reg_ctx_engine;
  localparam int DW = 16;
`ifdef REG_CTX_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_save, start_restore;
  logic          busy, done;
  logic [3:0]    SrcReg, DstReg, out_idx;
  logic [DW-1:0] SrcData, DstData, out_data, in_data, checksum;
  logic          WriteReg, out_valid, out_ready, in_valid, in_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] rf [16];
  logic [DW-1:0] rf_ref [16];
  logic [DW-1:0] load_vals [16];
  logic [DW-1:0] restore_vals [16];
  logic          load_all;

  always #5 clk = ~clk;

  reg_ctx_engine #(.DATA_W(DW), .FIRST_REG(0), .LAST_REG(15)) dut (
    .clk(clk), .rst(rst), .start_save(start_save), .start_restore(start_restore),
    .busy(busy), .done(done), .SrcReg(SrcReg), .SrcData(SrcData),
    .DstReg(DstReg), .DstData(DstData), .WriteReg(WriteReg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .checksum(checksum)
  );

  assign SrcData = rf[SrcReg];

  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < 16; i++) rf[i] <= load_vals[i];
    end else if (WriteReg) begin
      rf[DstReg] <= DstData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [DW-1:0] base);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      load_vals[i] = base + DW'(i);
      rf_ref[i]    = base + DW'(i);
    end
    load_all = 1'b1;
    @(negedge clk);
    load_all = 1'b0;
  endtask

  // Save the whole range; expected words come from rf_ref.
  task automatic do_save(input bit rand_ready, input int stall_word, input bit hold_restore);
    int k = 0, n = 0, done_at = -1, stalls = 0, stall_cnt = 0;
    bit bad_write = 0, pending = 0, rdy;
    logic [DW-1:0] exp_sum = '0, held_data = '0;
    logic [3:0] held_idx = '0;
    @(negedge clk);
    start_save = 1'b1;
    start_restore = hold_restore;
    @(posedge clk);
    #1 start_save = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (WriteReg) bad_write = 1;
      if (done) begin
        done_at = n;
        break;
      end
      if (pending) begin
        check("save_hold_valid", out_valid, 1);
        check("save_hold_data", out_data, held_data);
        check("save_hold_idx", out_idx, held_idx);
      end
      if (out_valid && k == stall_word && stall_cnt < 3) begin
        rdy = 0;
        stall_cnt++;
      end else begin
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      out_ready = rdy;
      pending = 0;
      if (out_valid) begin
        if (rdy) begin
          check("save_idx", out_idx, k[3:0]);
          check("save_data", out_data, rf_ref[k[3:0]]);
          exp_sum = exp_sum + rf_ref[k[3:0]];
          k++;
        end else begin
          stalls++;
          pending = 1;
          held_data = out_data;
          held_idx = out_idx;
        end
      end
    end
    check("save_words", k, 16);
    check("save_done_cycle", done_at, 33 + stalls);
    check("save_no_write", bad_write, 0);
    check("save_checksum", checksum, CK_EN ? exp_sum : '0);
    out_ready = 1'b0;
    start_restore = 1'b0;
    @(negedge clk);
    check("save_idle_busy", busy, 0);
    check("save_idle_done", done, 0);
  endtask

  // Restore restore_vals into the range; abort_at >= 0 resets during that word's write.
  task automatic do_restore(input bit rand_valid, input int abort_at);
    int k = 0, w = 0, n = 0, done_at = -1, waits = 0;
    bit vld;
    logic [DW-1:0] exp_sum = '0;
    @(negedge clk);
    start_restore = 1'b1;
    @(posedge clk);
    #1 start_restore = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (done) begin
        done_at = n;
        break;
      end
      if (WriteReg) begin
        check("rst_dst_reg", DstReg, w[3:0]);
        check("rst_dst_data", DstData, restore_vals[w[3:0]]);
        if (w == abort_at) begin
          in_valid = 1'b0;
          rst = 1'b0;
          #1;
          check("abort_write", WriteReg, 0);
          check("abort_busy", busy, 0);
          check("abort_in_ready", in_ready, 0);
          check("abort_checksum", checksum, 0);
          @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          check("abort_idle_busy", busy, 0);
          check("abort_src_reg", SrcReg, 0);
          check("abort_dst_reg", DstReg, 0);
          return;
        end
        rf_ref[w[3:0]] = restore_vals[w[3:0]];
        w++;
      end
      vld = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = vld;
      in_data = vld ? restore_vals[k[3:0]] : DW'($urandom);
      if (in_ready) begin
        if (vld) begin
          exp_sum = exp_sum + restore_vals[k[3:0]];
          k++;
        end else begin
          waits++;
        end
      end
    end
    in_valid = 1'b0;
    check("rst_writes", w, 16);
    check("rst_done_cycle", done_at, 33 + waits);
    check("rst_checksum", checksum, CK_EN ? exp_sum : '0);
    @(negedge clk);
    check("rst_idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    start_save = 1'b0;
    start_restore = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    load_all = 1'b0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_write", WriteReg, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_idx", out_idx, 0);
    check("reset_dst_data", DstData, 0);
    check("reset_checksum", checksum, 0);
    check("reset_src_reg", SrcReg, 0);
    check("reset_dst_reg", DstReg, 0);
    @(negedge clk);
    rst = 1'b1;

    preload(16'h1000);
    do_save(0, -1, 0);
    do_save(0, 5, 0);

    for (int i = 0; i < 16; i++) restore_vals[i] = 16'hA000 + 16'(i);
    do_restore(0, -1);
    for (int i = 0; i < 16; i++) check("rf_after_restore", rf[i], 16'hA000 + 16'(i));
    do_save(1, -1, 0);

    do_save(0, -1, 1);

    for (int i = 0; i < 16; i++) restore_vals[i] = 16'($urandom);
    do_restore(1, 7);
    for (int i = 8; i < 16; i++) check("abort_rf_untouched", rf[i], rf_ref[i]);
    check("abort_r7_untouched", rf[7], rf_ref[7]);
    do_save(1, -1, 0);

    for (int i = 0; i < 16; i++) restore_vals[i] = 16'(i + 1);
    do_restore(1, -1);
    check("checksum_136", checksum, CK_EN ? 16'd136 : 16'd0);
    repeat (3) @(negedge clk);
    check("checksum_hold", checksum, CK_EN ? 16'd136 : 16'd0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) restore_vals[i] = 16'($urandom);
      do_restore(1, -1);
      do_save(1, $urandom_range(0, 15), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
